// File: rtl/alu_operand_feeder_pkg.sv
// Shared types and defaults for the ALU operand feeder.
// State encoding is 3 bits wide to line up with the ALU controller's state width.
package alu_operand_feeder_pkg;

  localparam int DW_DEFAULT = 4;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_OPA  = 3'd1,
    S_OPB  = 3'd2,
    S_WAIT = 3'd3,
    S_HOLD = 3'd4
  } state_t;

endpackage

// File: rtl/alu_operand_feeder_if.sv
// Producer, ALU and result-consumer signals of the operand feeder.
// The feeder connects through slave; the environment it serves uses master.
interface alu_operand_feeder_if
  import alu_operand_feeder_pkg::*;
#(
  parameter int DW = DW_DEFAULT
);

  logic          push_valid;
  logic          push_ready;
  logic [DW-1:0] push_a;
  logic [DW-1:0] push_b;
  logic          alu_start;
  logic [DW-1:0] alu_data_in;
  logic          alu_done;
  logic [DW-1:0] alu_data_out;
  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_data;
  logic          res_err;

  modport master (
    output push_valid, push_a, push_b, alu_done, alu_data_out, res_ready,
    input  push_ready, alu_start, alu_data_in, res_valid, res_data, res_err
  );

  modport slave (
    input  push_valid, push_a, push_b, alu_done, alu_data_out, res_ready,
    output push_ready, alu_start, alu_data_in, res_valid, res_data, res_err
  );

endinterface

// File: rtl/alu_operand_feeder_operand_fifo.sv
// Circular operand-pair buffer with wrapping pointers and an occupancy counter.
// The caller guarantees push only when not full and pop only when not empty.
module operand_fifo
  import alu_operand_feeder_pkg::*;
#(
  parameter int DW    = DW_DEFAULT,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DW-1:0]          wr_a,
  input  logic [DW-1:0]          wr_b,
  output logic [DW-1:0]          rd_a,
  output logic [DW-1:0]          rd_b,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [2*DW-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {wr_a, wr_b};
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  assign {rd_a, rd_b} = mem[rd_ptr];
  assign full         = (level == LW'(DEPTH));
  assign empty        = (level == '0);

endmodule

// File: rtl/alu_operand_feeder.sv
// Buffers operand pairs and serialises each onto the ALU bus, then holds the ALU result.
// Define ALU_FEEDER_WATCHDOG_EN to abort an S_WAIT that outlasts TIMEOUT cycles.
module alu_operand_feeder
  import alu_operand_feeder_pkg::*;
#(
  parameter int DW      = DW_DEFAULT,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  alu_operand_feeder_if.slave    bus,
  output logic [$clog2(DEPTH):0] level
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
    $error("alu_operand_feeder: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
  end

  state_t        state;
  state_t        state_next;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic          timeout;
  logic [DW-1:0] head_a;
  logic [DW-1:0] head_b;
  logic [DW-1:0] a_q;
  logic [DW-1:0] b_q;
  logic [DW-1:0] res_data_q;

  // No bypass: a full FIFO refuses a push even on its pop cycle.
  assign bus.push_ready = !full;
  assign push           = bus.push_valid && !full;
  assign pop            = (state == S_IDLE) && !empty;

  operand_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wr_a  (bus.push_a),
    .wr_b  (bus.push_b),
    .rd_a  (head_a),
    .rd_b  (head_b),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (!empty) state_next = S_OPA;
      S_OPA:   state_next = S_OPB;
      S_OPB:   state_next = S_WAIT;
      S_WAIT:  if (bus.alu_done || timeout) state_next = S_HOLD;
      S_HOLD:  if (bus.res_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.alu_start   = 1'b0;
    bus.alu_data_in = '0;
    bus.res_valid   = 1'b0;
    case (state)
      S_OPA: begin
        bus.alu_start   = 1'b1;
        bus.alu_data_in = a_q;
      end
      S_OPB, S_WAIT: bus.alu_data_in = b_q;
      S_HOLD:        bus.res_valid   = 1'b1;
      default: ;
    endcase
  end

  // A completed result wins over a timeout that lands on the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      res_data_q <= '0;
    end else begin
      if (pop) begin
        a_q <= head_a;
        b_q <= head_b;
      end
      if (state == S_WAIT && bus.alu_done) res_data_q <= bus.alu_data_out;
      else if (timeout)                    res_data_q <= '0;
    end
  end

  assign bus.res_data = res_data_q;

`ifdef ALU_FEEDER_WATCHDOG_EN
  localparam int WW = $clog2(TIMEOUT + 1);

  logic [WW-1:0] wd_cnt;
  logic          res_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt    <= '0;
      res_err_q <= 1'b0;
    end else begin
      if (state == S_OPB)       wd_cnt <= '0;
      else if (state == S_WAIT) wd_cnt <= wd_cnt + WW'(1);
      if (state == S_WAIT && bus.alu_done) res_err_q <= 1'b0;
      else if (timeout)                    res_err_q <= 1'b1;
    end
  end

  assign timeout     = (state == S_WAIT) && (wd_cnt == WW'(TIMEOUT - 1));
  assign bus.res_err = res_err_q;
`else
  assign timeout     = 1'b0;
  assign bus.res_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_operand_feeder.sv
// Directed bench for alu_operand_feeder with a stub adder standing in for the ALU.
// The watchdog step runs only when ALU_FEEDER_WATCHDOG_EN is defined.
module tb_alu_operand_feeder;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] level;
  int         checks = 0;
  int         errors = 0;

  logic [1:0] stub_phase;
  logic [3:0] stub_a;
  logic [3:0] stub_sum;
  int         stub_cnt;
  bit         stub_enable = 1'b1;

  alu_operand_feeder_if #(.DW(4)) bus ();

  alu_operand_feeder #(
    .DW      (4),
    .DEPTH   (4),
    .TIMEOUT (15)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .level (level)
  );

  always #5 clk = ~clk;

  // Stub ALU: takes A on the start cycle, B next cycle, raises done one cycle later with A+B.
  always @(posedge clk) begin
    if (rst) begin
      stub_phase       <= 2'd0;
      stub_cnt         <= 0;
      bus.alu_done     <= 1'b0;
      bus.alu_data_out <= 4'd0;
    end else begin
      bus.alu_done <= 1'b0;
      case (stub_phase)
        2'd0: if (bus.alu_start) begin
          stub_a     <= bus.alu_data_in;
          stub_phase <= 2'd1;
        end
        2'd1: begin
          stub_sum   <= stub_a + bus.alu_data_in;
          stub_cnt   <= 0;
          stub_phase <= 2'd2;
        end
        default: if (stub_cnt > 0) begin
          stub_cnt <= stub_cnt - 1;
        end else if (stub_enable) begin
          bus.alu_done     <= 1'b1;
          bus.alu_data_out <= stub_sum;
          stub_phase       <= 2'd0;
        end
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [3:0] a, input logic [3:0] b);
    bus.push_valid = valid;
    bus.push_a     = a;
    bus.push_b     = b;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic waitResult(input int budget);
    int n = 0;
    while (!bus.res_valid && n < budget) begin
      tick();
      n++;
    end
    checkOutput("res_valid_wait", 32'(bus.res_valid), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    int         np;
    int         nr;
    int         cyc;
    bit         acc;
    logic [3:0] exp4;

    rst           = 1'b1;
    bus.res_ready = 1'b0;
    applyStimulus(1'b0, 4'd0, 4'd0);
    tick();
    tick();
    $display("[TB] reset state");
    checkOutput("rst_push_ready", 32'(bus.push_ready), 32'd1);
    checkOutput("rst_level", 32'(level), 32'd0);
    checkOutput("rst_alu_start", 32'(bus.alu_start), 32'd0);
    checkOutput("rst_alu_data_in", 32'(bus.alu_data_in), 32'd0);
    checkOutput("rst_res_valid", 32'(bus.res_valid), 32'd0);
    checkOutput("rst_res_data", 32'(bus.res_data), 32'd0);
    checkOutput("rst_res_err", 32'(bus.res_err), 32'd0);
    rst = 1'b0;
    tick();

    $display("[TB] single pair 3,5");
    applyStimulus(1'b1, 4'd3, 4'd5);
    tick();
    checkOutput("single_level_after_push", 32'(level), 32'd1);
    checkOutput("single_start_idle", 32'(bus.alu_start), 32'd0);
    applyStimulus(1'b0, 4'd0, 4'd0);
    tick();
    checkOutput("single_start_opa", 32'(bus.alu_start), 32'd1);
    checkOutput("single_data_a", 32'(bus.alu_data_in), 32'd3);
    checkOutput("single_level_after_pop", 32'(level), 32'd0);
    tick();
    checkOutput("single_start_opb", 32'(bus.alu_start), 32'd0);
    checkOutput("single_data_b", 32'(bus.alu_data_in), 32'd5);
    tick();
    checkOutput("single_data_wait", 32'(bus.alu_data_in), 32'd5);
    checkOutput("single_start_wait", 32'(bus.alu_start), 32'd0);
    waitResult(20);
    checkOutput("single_res_data", 32'(bus.res_data), 32'd8);
    checkOutput("single_res_err", 32'(bus.res_err), 32'd0);
    repeat (3) tick();
    checkOutput("single_res_held", 32'(bus.res_valid), 32'd1);
    checkOutput("single_data_hold", 32'(bus.alu_data_in), 32'd0);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    checkOutput("single_res_taken", 32'(bus.res_valid), 32'd0);
    checkOutput("single_res_data_kept", 32'(bus.res_data), 32'd8);

    $display("[TB] fill and backpressure");
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1'b1, 4'(k), 4'(k + 1));
      tick();
    end
    checkOutput("fill_level", 32'(level), 32'd4);
    checkOutput("fill_push_ready", 32'(bus.push_ready), 32'd0);
    applyStimulus(1'b1, 4'd6, 4'd7);
    repeat (3) tick();
    checkOutput("fill_sixth_refused", 32'(bus.push_ready), 32'd0);
    checkOutput("fill_level_stays", 32'(level), 32'd4);
    applyStimulus(1'b0, 4'd0, 4'd0);
    bus.res_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      waitResult(30);
      checkOutput($sformatf("fill_order_%0d", k), 32'(bus.res_data), 32'(2 * k + 1));
      tick();
    end
    bus.res_ready = 1'b0;

    $display("[TB] simultaneous push and pop");
    applyStimulus(1'b1, 4'd7, 4'd1);
    tick();
    applyStimulus(1'b1, 4'd2, 4'd2);
    tick();
    applyStimulus(1'b1, 4'd6, 4'd3);
    tick();
    applyStimulus(1'b0, 4'd0, 4'd0);
    waitResult(20);
    checkOutput("sim_first_res", 32'(bus.res_data), 32'd8);
    checkOutput("sim_level_before", 32'(level), 32'd2);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    applyStimulus(1'b1, 4'd8, 4'd8);
    tick();
    applyStimulus(1'b0, 4'd0, 4'd0);
    checkOutput("sim_level_after", 32'(level), 32'd2);
    checkOutput("sim_start", 32'(bus.alu_start), 32'd1);
    checkOutput("sim_data_a", 32'(bus.alu_data_in), 32'd2);
    bus.res_ready = 1'b1;
    waitResult(20);
    checkOutput("sim_res_2", 32'(bus.res_data), 32'd4);
    tick();
    waitResult(20);
    checkOutput("sim_res_3", 32'(bus.res_data), 32'd9);
    tick();
    waitResult(20);
    checkOutput("sim_res_4", 32'(bus.res_data), 32'd0);
    tick();

    $display("[TB] pointer wrap-around stream");
    np  = 0;
    nr  = 0;
    cyc = 0;
    applyStimulus(1'b1, 4'd0, 4'd1);
    while (nr < 10 && cyc < 300) begin
      acc = bus.push_valid && bus.push_ready;
      if (bus.res_valid) begin
        exp4 = 4'(2 * nr + 1);
        checkOutput($sformatf("wrap_res_%0d", nr), 32'(bus.res_data), 32'(exp4));
        nr++;
      end
      tick();
      cyc++;
      if (acc) begin
        np++;
        if (np < 10) applyStimulus(1'b1, 4'(np), 4'(np + 1));
        else         applyStimulus(1'b0, 4'd0, 4'd0);
      end
    end
    applyStimulus(1'b0, 4'd0, 4'd0);
    checkOutput("wrap_count", 32'(nr), 32'd10);
    checkOutput("wrap_level_empty", 32'(level), 32'd0);
    bus.res_ready = 1'b0;

    $display("[TB] reset mid-operation");
    applyStimulus(1'b1, 4'd1, 4'd1);
    tick();
    applyStimulus(1'b1, 4'd2, 4'd2);
    tick();
    applyStimulus(1'b1, 4'd3, 4'd3);
    tick();
    applyStimulus(1'b0, 4'd0, 4'd0);
    tick();
    checkOutput("mid_level_queued", 32'(level), 32'd2);
    checkOutput("mid_data_wait", 32'(bus.alu_data_in), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_level", 32'(level), 32'd0);
    checkOutput("mid_rst_push_ready", 32'(bus.push_ready), 32'd1);
    checkOutput("mid_rst_alu_start", 32'(bus.alu_start), 32'd0);
    checkOutput("mid_rst_alu_data_in", 32'(bus.alu_data_in), 32'd0);
    checkOutput("mid_rst_res_valid", 32'(bus.res_valid), 32'd0);
    checkOutput("mid_rst_res_data", 32'(bus.res_data), 32'd0);
    checkOutput("mid_rst_res_err", 32'(bus.res_err), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    applyStimulus(1'b1, 4'd4, 4'd5);
    tick();
    applyStimulus(1'b0, 4'd0, 4'd0);
    waitResult(20);
    checkOutput("mid_after_res", 32'(bus.res_data), 32'd9);
    checkOutput("mid_after_err", 32'(bus.res_err), 32'd0);
    checkOutput("mid_after_level", 32'(level), 32'd0);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;

`ifdef ALU_FEEDER_WATCHDOG_EN
    $display("[TB] watchdog timeout");
    stub_enable = 1'b0;
    applyStimulus(1'b1, 4'd2, 4'd3);
    tick();
    applyStimulus(1'b0, 4'd0, 4'd0);
    repeat (17) tick();
    checkOutput("wd_not_yet", 32'(bus.res_valid), 32'd0);
    tick();
    checkOutput("wd_hold", 32'(bus.res_valid), 32'd1);
    checkOutput("wd_res_err", 32'(bus.res_err), 32'd1);
    checkOutput("wd_res_data", 32'(bus.res_data), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
